al_clk_key_entry: RTL

Keypad entry stage for the alarm clock. It turns debounced key events into a 4-digit BCD HHMM value and validates it as a 24-hour time. A valid entry is committed as a one-cycle load strobe plus time value that drive `load_new_time`/`time_in` of `al_clk_counter`, or the alarm register's load inputs. Runs in the `clk256` domain produced by `FREQ_DIV`, directly upstream of `al_clk_counter`.

---
 rtl/al_clk_key_entry.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/al_clk_key_entry.sv
// ---------------------------------------------------------------------------
// al_clk_key_entry
//   Keypad entry stage for the alarm clock (clk256 domain). Collects digit
//   presses into a 4-digit BCD HHMM buffer, checks the value as a 24-hour
//   time on SET_TIME / SET_ALARM, and commits it as a one-cycle load strobe
//   plus a held time value for al_clk_counter or the alarm register.
//
// Ports
//   clk256          in   1  clock, rising edge
//   reset           in   1  asynchronous, active-low
//   key_valid       in   1  key held (synchronised, debounced)
//   key_code        in   4  0-9 digit, A SET_TIME, B SET_ALARM, C CLEAR, D-F ignored
//   key_buffer      out 16  digits entered so far, newest in [3:0]
//   entry_active    out  1  high in ENTRY
//   new_time        out 16  last committed HHMM
//   load_new_time   out  1  one-cycle commit strobe, current time
//   load_new_alarm  out  1  one-cycle commit strobe, alarm time
//   entry_error     out  1  high in ERROR
//
// state  | meaning
// IDLE   | no entry in progress
// ENTRY  | one or more digits entered, timeout timer running
// COMMIT | single cycle, load strobe asserted
// ERROR  | rejected SET, timeout timer running
// ---------------------------------------------------------------------------
module al_clk_key_entry #(
    parameter int TIMEOUT_TICKS = 2560
) (
    input  logic        clk256,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [15:0] key_buffer,
    output logic        entry_active,
    output logic [15:0] new_time,
    output logic        load_new_time,
    output logic        load_new_alarm,
    output logic        entry_error
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENTRY  = 2'd1,
        ST_COMMIT = 2'd2,
        ST_ERROR  = 2'd3
    } state_t;

    localparam logic [11:0] TIMER_TC = 12'(TIMEOUT_TICKS - 1);

    state_t      state, state_nxt;
    logic        key_prev;
    logic [2:0]  count, count_nxt;
    logic [11:0] timer, timer_nxt;
    logic [15:0] buf_nxt;
    logic [15:0] new_time_nxt;
    logic        alarm_nxt;

    logic press;
    logic is_digit, is_set, is_clear;
    logic entry_ok;
    logic acted;

    assign press    = key_valid & ~key_prev;
    assign is_digit = (key_code <= 4'd9);
    assign is_set   = (key_code == 4'hA) || (key_code == 4'hB);
    assign is_clear = (key_code == 4'hC);

    // 24-hour check on H1 H0 : M1 M0
    assign entry_ok = (count == 3'd4)
                   && (key_buffer[15:12] <= 4'd2)
                   && (key_buffer[11:8]  <= 4'd9)
                   && ((key_buffer[15:12] < 4'd2) || (key_buffer[11:8] <= 4'd3))
                   && (key_buffer[7:4]   <= 4'd5)
                   && (key_buffer[3:0]   <= 4'd9);

    always_ff @(posedge clk256 or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            key_prev       <= 1'b0;
            count          <= 3'd0;
            timer          <= 12'd0;
            key_buffer     <= 16'h0000;
            new_time       <= 16'h0000;
            load_new_time  <= 1'b0;
            load_new_alarm <= 1'b0;
            entry_active   <= 1'b0;
            entry_error    <= 1'b0;
        end else begin
            state          <= state_nxt;
            key_prev       <= key_valid;
            count          <= count_nxt;
            timer          <= timer_nxt;
            key_buffer     <= buf_nxt;
            new_time       <= new_time_nxt;
            // Outputs are registered copies of the next-state decode so they
            // line up with the state they describe.
            load_new_time  <= (state_nxt == ST_COMMIT) && !alarm_nxt;
            load_new_alarm <= (state_nxt == ST_COMMIT) &&  alarm_nxt;
            entry_active   <= (state_nxt == ST_ENTRY);
            entry_error    <= (state_nxt == ST_ERROR);
        end
    end

    always_comb begin
        state_nxt    = state;
        count_nxt    = count;
        buf_nxt      = key_buffer;
        new_time_nxt = new_time;
        alarm_nxt    = 1'b0;
        acted        = 1'b0;

        if (state == ST_COMMIT) begin
            // Any press sampled here is dropped.
            state_nxt = ST_IDLE;
            buf_nxt   = 16'h0000;
            count_nxt = 3'd0;
        end else if (press && is_digit) begin
            acted     = 1'b1;
            buf_nxt   = {key_buffer[11:0], key_code};
            count_nxt = (count == 3'd4) ? 3'd4 : count + 3'd1;
            state_nxt = ST_ENTRY;
        end else if (press && is_clear) begin
            acted     = 1'b1;
            buf_nxt   = 16'h0000;
            count_nxt = 3'd0;
            state_nxt = ST_IDLE;
        end else if (press && is_set) begin
            acted = 1'b1;
            if ((state == ST_ENTRY) && entry_ok) begin
                new_time_nxt = key_buffer;
                alarm_nxt    = key_code[0];
                state_nxt    = ST_COMMIT;
            end else begin
                state_nxt = ST_ERROR;
            end
        end else if ((state != ST_IDLE) && (timer == TIMER_TC)) begin
            // Timeout: same effect as CLEAR. Ignored codes D-F land here too
            // since they are not acted-on presses.
            buf_nxt   = 16'h0000;
            count_nxt = 3'd0;
            state_nxt = ST_IDLE;
        end

        if ((state_nxt == ST_ENTRY) || (state_nxt == ST_ERROR)) begin
            timer_nxt = acted ? 12'd0 : timer + 12'd1;
        end else begin
            timer_nxt = 12'd0;
        end
    end

endmodule
